// File: rtl/cdc_send_pkg.sv
// Shared types for the cdc_send handshake sender: FSM state encoding and a
// constant clog2 used to size the timeout counter.
package cdc_send_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // SETUP is bounded to 1..15, so four bits cover the setup count.
  localparam int SETUP_CW = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// STAGES-deep single-bit synchronizer for an asynchronous input; q lags d by
// STAGES clocks, no backpressure, resets asynchronously to 0.
module sync_ff #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_send.sv
// 4-phase req/ack sender: word held on tx_data, tx_req raised SETUP clocks after
// accept; done after 1+SETUP+2*SYNC+2 clocks best case. ready low while busy or ack_s high.
module cdc_send
  import cdc_send_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SYNC    = 3,
  parameter int SETUP   = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             done,
  output logic             err
);

  localparam int TW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMR_MAX = '1;
  localparam logic [SETUP_CW-1:0] SETUP_LAST = SETUP_CW'(SETUP - 1);

  logic                ack_s;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                errd_q, errd_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [SETUP_CW-1:0] scnt_q, scnt_d;
  logic                tmr_hit;

  sync_ff #(.STAGES(SYNC)) u_ack_sync (
    .clk  (clk),
    .arstn(arstn),
    .d    (tx_ack),
    .q    (ack_s)
  );

  assign tmr_hit = TMO_EN && (tmr_q == TMO_LAST);
  assign ready   = (state_q == ST_IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    errd_d  = errd_q;
    scnt_d  = scnt_q;
    tmr_d   = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (valid && ready) begin
          data_d  = din;
          tmr_d   = '0;
          scnt_d  = '0;
          errd_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (scnt_q == SETUP_LAST) begin
          req_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_REQ;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = ST_RELEASE;
        end else if (tmr_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          errd_d  = 1'b1;
          tmr_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // errd_q keeps a transfer from reporting both err and done.
        if (!ack_s) begin
          done_d  = !errd_q;
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else if (tmr_hit) begin
          err_d   = !errd_q;
          errd_d  = 1'b1;
          tmr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errd_q  <= 1'b0;
      tmr_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      errd_q  <= errd_d;
      tmr_q   <= tmr_d;
      scnt_q  <= scnt_d;
    end
  end

  assign tx_data = data_q;
  assign tx_req  = req_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cdc_send.sv
// Directed bench for cdc_send: behavioural receiver, scoreboard of accepted
// words checked at each tx_req rise and each done pulse.
module tb_cdc_send;

  localparam int WIDTH   = 8;
  localparam int SYNC    = 3;
  localparam int SETUP   = 1;
  localparam int TIMEOUT = 16;
  localparam int RX_DLY  = 2;

  logic             clk   = 1'b0;
  logic             arstn = 1'b0;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic             ready, tx_req, tx_ack, done, err;
  logic [WIDTH-1:0] tx_data;

  logic rx_en   = 1'b0;
  logic rx_ack  = 1'b0;
  logic man_ack = 1'b0;
  int   rx_cnt  = 0;

  int   checks = 0, errors = 0;
  int   done_cnt = 0, err_cnt = 0, req_len = 0, last_req_len = 0;
  logic req_prev = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  assign tx_ack = rx_en ? rx_ack : man_ack;

  always #5 clk = ~clk;

  cdc_send #(
    .WIDTH(WIDTH), .SYNC(SYNC), .SETUP(SETUP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .arstn  (arstn),
    .din    (din),
    .valid  (valid),
    .ready  (ready),
    .tx_data(tx_data),
    .tx_req (tx_req),
    .tx_ack (tx_ack),
    .done   (done),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver: follows tx_req with RX_DLY clocks of latency in both directions.
  always @(negedge clk) begin
    if (!rx_en) begin
      rx_ack = 1'b0;
      rx_cnt = 0;
    end else if (tx_req != rx_ack) begin
      rx_cnt++;
      if (rx_cnt >= RX_DLY) begin
        rx_ack = tx_req;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!arstn) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (tx_req && !req_prev) begin
        check("queue_nonempty_at_req", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_data_at_req", 32'(tx_data), 32'(exp_q[0]));
      end
      if (tx_req) req_len++;
      else if (req_prev) begin
        last_req_len = req_len;
        req_len = 0;
      end
      if (done || err) check("done_err_exclusive", 32'(done && err), 32'd0);
      if (done) begin
        done_cnt++;
        check("queue_nonempty_at_done", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("tx_data_at_done", 32'(tx_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (err) begin
        err_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      req_prev = tx_req;
    end
  end

  task automatic accept_word(input logic [WIDTH-1:0] w);
    int n = 0;
    @(negedge clk);
    din   = w;
    valid = 1'b1;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(ready), 32'd1);
    exp_q.push_back(w);
    @(posedge clk);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_during", 32'(tx_req), 32'd0);
    arstn = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_req", 32'(tx_req), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);

    // Single word with a responsive receiver
    rx_en = 1'b1;
    accept_word(8'hA5);
    @(negedge clk);
    valid = 1'b0;
    check("t1_setup_ready", 32'(ready), 32'd0);
    check("t1_setup_req", 32'(tx_req), 32'd0);
    check("t1_data_pre_req", 32'(tx_data), 32'hA5);
    @(negedge clk);
    check("t1_req_rise", 32'(tx_req), 32'd1);
    wait_done(1);
    check("t1_ready_back", 32'(ready), 32'd1);
    check("t1_no_err", 32'(err_cnt), 32'd0);

    // Back-to-back words with valid held high
    accept_word(8'h01);
    accept_word(8'h02);
    accept_word(8'h03);
    @(negedge clk);
    valid = 1'b0;
    wait_done(4);
    repeat (10) @(negedge clk);
    check("t2_done_total", 32'(done_cnt), 32'd4);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t2_no_err", 32'(err_cnt), 32'd0);

    // Receiver never acknowledges
    rx_en = 1'b0;
    accept_word(8'h77);
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (err_cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_err_pulse", 32'(err_cnt), 32'd1);
    check("t3_req_len", 32'(last_req_len), 32'(TIMEOUT));
    repeat (4) @(negedge clk);
    check("t3_single_err", 32'(err_cnt), 32'd1);
    check("t3_no_done", 32'(done_cnt), 32'd4);
    check("t3_ready_idle", 32'(ready), 32'd1);
    check("t3_req_low", 32'(tx_req), 32'd0);

    // Ack held high through reset release
    man_ack = 1'b1;
    arstn   = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("t4_ready_ack_high", 32'(ready), 32'd0);
    din   = 8'h3C;
    valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_ignored_ready", 32'(ready), 32'd0);
    check("t4_ignored_req", 32'(tx_req), 32'd0);
    check("t4_ignored_data", 32'(tx_data), 32'd0);
    man_ack = 1'b0;
    repeat (SYNC - 1) @(negedge clk);
    check("t4_ready_before_sync", 32'(ready), 32'd0);
    @(negedge clk);
    check("t4_ready_after_sync", 32'(ready), 32'd1);
    exp_q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rx_en = 1'b1;
    wait_done(5);

    // Reset while in REQ
    accept_word(8'h5A);
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!tx_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_req", 32'(tx_req), 32'd1);
    #2 arstn = 1'b0;
    #1;
    check("t5_async_clear", 32'({tx_req, done, err}), 32'd0);
    exp_q.delete();
    rx_en = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("t5_ready_after_rst", 32'(ready), 32'd1);
    rx_en = 1'b1;
    accept_word(8'h96);
    @(negedge clk);
    valid = 1'b0;
    wait_done(6);

    // din change and ack glitch while in SETUP
    rx_en = 1'b0;
    accept_word(8'hC3);
    @(negedge clk);
    din   = 8'h11;
    valid = 1'b0;
    #1 man_ack = 1'b1;
    #2 man_ack = 1'b0;
    check("t6_data_hold", 32'(tx_data), 32'hC3);
    rx_en = 1'b1;
    @(negedge clk);
    check("t6_req_rise", 32'(tx_req), 32'd1);
    check("t6_data_in_req", 32'(tx_data), 32'hC3);
    wait_done(7);
    check("t6_err_total", 32'(err_cnt), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_send.md
Name: cdc_send

Overview:
- Sending end of a 4-phase req/ack handshake that transfers a WIDTH-bit word from the local `clk` domain to an asynchronous receiver.
- The word is captured and held stable, then `tx_req` is raised.
- The returning asynchronous `tx_ack` is synchronized internally and the full 4-phase cycle is completed.
- A timeout aborts a transfer when the far side stops responding.

Parameters:
- WIDTH, 8, data word width (1..64)
- SYNC, 3, ack synchronizer depth in flops (2..4)
- SETUP, 1, clocks `tx_data` is held stable before `tx_req` rises (1..15)
- TIMEOUT, 1023, max clocks waiting in REQ or RELEASE; 0 disables timeout

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- din  in  WIDTH  word to send
- valid  in  1  local request; accepted when valid&ready
- ready  out  1  high only in IDLE with synchronized ack low
- tx_data  out  WIDTH  registered data to receiver; stable from capture until RELEASE exits
- tx_req  out  1  registered request, glitch-free
- tx_ack  in  1  asynchronous acknowledge from receiver
- done  out  1  one-cycle pulse, transfer completed normally
- err  out  1  one-cycle pulse, transfer aborted by timeout

Behaviour:
- Reset values (async on arstn low):
  - state=IDLE; tx_req=0, tx_data=0, done=0, err=0, timer=0, sync chain=0.
  - ready follows from state, so ready=1 after reset once ack_s=0.
- ack_s = tx_ack passed through SYNC flops; ack_s lags tx_ack by SYNC clocks. The FSM uses only ack_s.
- States: IDLE, SETUP, REQ, RELEASE.
- IDLE:
  - ready = (ack_s==0).
  - On valid&ready: tx_data<=din, timer<=0, go to SETUP.
  - valid while ready=0 is ignored; no capture.
- SETUP:
  - Count SETUP clocks; tx_req stays 0.
  - On the last count: tx_req<=1, timer<=0, go to REQ.
  - With SETUP=1, tx_req rises on the second edge after acceptance.
- REQ:
  - Wait for ack_s=1, then tx_req<=0, timer<=0, go to RELEASE.
  - If TIMEOUT!=0 and timer reaches TIMEOUT-1: tx_req<=0, err<=1 for one clock, go to RELEASE.
- RELEASE:
  - Wait for ack_s=0, then done<=1 for one clock (unless err already fired this transfer), go to IDLE.
  - If TIMEOUT!=0 and timer reaches TIMEOUT-1: err<=1 for one clock, go to IDLE. ready stays low until ack_s falls.
- tx_data changes only on acceptance in IDLE. It is never modified while tx_req=1 or ack_s=1.
- done and err are never high together. At most one of them pulses per accepted word.
- Timer: saturating counter, width clog2(TIMEOUT+1), min 1. It is cleared on every state entry.
- Best-case cycle count, acceptance to done, with an immediately responding receiver: 1 + SETUP + SYNC + 1 + SYNC + 1.
- Boundaries:
  - ack_s already high at reset release: ready=0 until it falls.
  - Spurious ack_s pulse in IDLE/SETUP is ignored. The SETUP→REQ transition is unaffected.
  - ack_s falling before tx_req dropped is impossible by protocol. If it happens, the FSM stays in REQ until it rises again or the timeout fires.
  - Reset mid-transfer forces tx_req=0 immediately (asynchronously). The receiver must tolerate an aborted request.

Decomposition:
- Shared package: state encoding constants (IDLE=0, SETUP=1, REQ=2, RELEASE=3) and a clog2 function for timer width.
- One natural sub-module: `sync_ff`.
  - Parameterised SYNC-deep single-bit flop chain with asynchronous active-low reset to 0.
  - Reusable for other async inputs.

Test Plan:
- WIDTH=8, SYNC=3, SETUP=1. valid with din=0xA5; receiver acks 2 clocks after tx_req↑ and drops ack 2 clocks after tx_req↓ -> tx_data=0xA5 before tx_req↑, tx_req↑ 2 edges after accept, exactly one done pulse, ready returns, err never set.
- Back-to-back words 0x01, 0x02, 0x03 with valid held high -> each captured only in IDLE. Three done pulses, tx_data sequence 01, 02, 03, no word lost or repeated.
- TIMEOUT=16, receiver never acks -> tx_req high exactly 16 clocks, then tx_req↓, one err pulse, no done, return to IDLE.
- tx_ack held high through reset release -> ready=0. valid with 0x3C is ignored until ack drops; after ack drops for SYNC clocks, ready=1 and 0x3C is accepted.
- arstn asserted in REQ -> tx_req, done, err go 0 immediately. After release: ready=1 with ack low, and a new transfer completes normally.
- Change din and pulse tx_ack low→high→low while in SETUP -> tx_data unchanged, FSM proceeds to REQ, no done or err.
